dbg_inst_seq: RTL and testbench
===============================

# dbg_inst_seq

Debug abstract-command sequencer for the cotm32 core. Accepts GPR/CSR read and write commands from the debug side, encodes each into a short RV32I/Zicsr instruction sequence and issues it into the core's instruction-injection path one instruction at a time, waiting for each result before the next issue. It returns a single response carrying read data or the old CSR value, plus an error flag. It is the producer of the instruction words that the control unit decodes.

## Interface
- SCRATCH_REG, 31, GPR index used as the temporary for CSR writes; must be nonzero.
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_op  in  2  0 REG_READ, 1 REG_WRITE, 2 CSR_READ, 3 CSR_WRITE
- i_cmd_addr  in  12  CSR address; bits [4:0] are the GPR index for REG ops
- i_cmd_data  in  32  write data
- o_inst_valid  out  1  injected instruction valid
- o_inst  out  32  injected instruction word
- i_inst_ready  in  1  core accepts o_inst
- i_res_valid  in  1  result of the outstanding instruction
- i_res_data  in  32  ALU result, or CSR read value for Zicsr instructions
- i_res_exc  in  1  the instruction trapped (illegal, ecall, ebreak)
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_data  out  32  response data
- o_rsp_err  out  1  an instruction in the sequence trapped

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A step counter indexes the micro-sequence for the latched op.
- Command latched on i_cmd_valid & o_cmd_ready; op, address and data are held until RESP.
- hi = data[31:12] + data[11] (mod 2^20); lo = data[11:0], sign-extended by ADDI. Reconstructs any 32-bit value.
- Sequences; steps marked * capture i_res_data into the response register:
  - REG_READ: *ADDI x0,xN,0.
  - REG_WRITE: LUI xN,hi; ADDI xN,xN,lo. Response data is 0.
  - CSR_READ: *CSRRS x0,csr,x0.
  - CSR_WRITE: [save] LUI xT,hi; ADDI xT,xT,lo; *CSRRW x0,csr,xT; [restore].
- Encodings:
  - ADDI = {imm12, rs1, 3'b000, rd, 7'b0010011}
  - LUI = {imm20, rd, 7'b0110111}
  - CSRRS = {csr, 5'd0, 3'b010, 5'd0, 7'b1110011}
  - CSRRW = {csr, xT, 3'b001, 5'd0, 7'b1110011}
- Each step: ISSUE drives o_inst_valid=1 with o_inst stable until i_inst_ready. Handshake → WAIT. i_res_valid in WAIT → next step, or RESP after the last step.
- i_res_exc with i_res_valid: o_rsp_err is set (sticky for this command) and the remaining non-restore steps are skipped. The restore steps still run if the save step completed. A trap during restore keeps err=1 and goes directly to RESP.
- REG ops on x0 are issued normally; REG_READ x0 returns whatever the core reports (0).
- RESP: o_rsp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response.

## Timing
- Reset (async, any state): IDLE, step=0; o_cmd_ready=1; o_inst_valid=0, o_inst=0; o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0.
- One instruction outstanding at most. i_res_valid is ignored outside WAIT, including in the handshake cycle itself.
- Zero-stall latency from command accept to o_rsp_valid: 3·N cycles for an N-step sequence (REG_READ 3, REG_WRITE 6).
- o_cmd_ready deasserts the cycle after accept; a new command is accepted no earlier than the cycle after the RESP cycle.
- o_inst and o_inst_valid are registered outputs with no combinational path from i_inst_ready.

## Configuration
- DBG_SCRATCH_SAVE_EN defined: CSR_WRITE prepends save step ADDI x0,xT,0, capturing the old xT into a save register. It appends restore steps LUI xT,shi and ADDI xT,xT,slo. CSR_WRITE = 6 steps; xT is architecturally preserved.
- Undefined: no save or restore; CSR_WRITE = 3 steps; xT is clobbered with the written value; the save register is not built.

## Test plan
- REG_READ x7, core returns 0x1234_5678 → o_inst=0x00038013, o_rsp_data=0x12345678, err=0, rsp 3 cycles after accept.
- REG_WRITE x10=0x0000_0FFF → LUI x10,0x00001 (0x00001537), then ADDI x10,x10,-1 (0xFFF50513); rsp_data=0.
- CSR_READ 0x300, result 0x1800 → o_inst=0x30002073, rsp_data=0x1800.
- CSR_WRITE 0x341=0x8000_0000, SAVE_EN, x31 holds 0xDEAD_BEEF → 6 instructions, the last two reload 0xDEADBEEF into x31; rsp_data=old mepc.
- CSR_READ 0xFFF with i_res_exc=1 → rsp_err=1 and no further instructions. Next command runs with err=0.
- i_inst_ready held low 5 cycles mid-REG_WRITE, then i_rst_n pulsed low → o_inst stable while stalled; all outputs at reset values, o_cmd_ready=1 after release.

Source files
------------

// File: rtl/dbg_inst_seq_if.sv
// rtl/dbg_inst_seq_if.sv - command, instruction-injection and response signals of dbg_inst_seq
interface dbg_inst_seq_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op;
  logic [11:0] i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic        i_inst_ready;
  logic        i_res_valid;
  logic [31:0] i_res_data;
  logic        i_res_exc;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
    input  i_inst_ready, i_res_valid, i_res_data, i_res_exc,
    output o_cmd_ready, o_inst_valid, o_inst, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
    output i_inst_ready, i_res_valid, i_res_data, i_res_exc,
    input  o_cmd_ready, o_inst_valid, o_inst, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/dbg_inst_seq.sv
// rtl/dbg_inst_seq.sv - debug abstract command to RV32I/Zicsr instruction sequencer
// Optional scratch-register save/restore around CSR writes: DBG_SCRATCH_SAVE_EN
module dbg_inst_seq #(
  parameter logic [4:0] SCRATCH_REG = 5'd31
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dbg_inst_seq_if.slave bus
);
  localparam logic [1:0] OP_REG_READ  = 2'd0;
  localparam logic [1:0] OP_REG_WRITE = 2'd1;
  localparam logic [1:0] OP_CSR_READ  = 2'd2;
  localparam logic [1:0] OP_CSR_WRITE = 2'd3;
`ifdef DBG_SCRATCH_SAVE_EN
  localparam logic [2:0] CSRW_CAP     = 3'd3;
  localparam logic [2:0] CSRW_LAST    = 3'd5;
  localparam logic [2:0] CSRW_RESTORE = 3'd4;
`else
  localparam logic [2:0] CSRW_CAP     = 3'd2;
  localparam logic [2:0] CSRW_LAST    = 3'd2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic        accept, load_inst, res_ok, capture;
  logic [2:0]  last_step;
  logic [1:0]  e_op;
  logic [11:0] e_addr;
  logic [31:0] e_data;
  logic [2:0]  e_step;
  logic [19:0] e_hi;
  logic [31:0] e_inst;
`ifdef DBG_SCRATCH_SAVE_EN
  logic [31:0] save_q;
`endif

  function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Upper part pre-compensated for the sign extension of the ADDI low part (takes v[31:11]).
  function automatic logic [19:0] hi_part(input logic [20:0] v);
    return v[20:1] + {19'd0, v[0]};
  endfunction

  assign accept    = (state_q == S_IDLE) && bus.i_cmd_valid;
  assign res_ok    = (state_q == S_WAIT) && bus.i_res_valid;
  assign load_inst = accept || ((state_q == S_ISSUE) && !inst_valid_q);

  always_comb begin
    last_step = 3'd0;
    capture   = 1'b0;
    case (op_q)
      OP_REG_READ:  capture = (step_q == 3'd0);
      OP_REG_WRITE: last_step = 3'd1;
      OP_CSR_READ:  capture = (step_q == 3'd0);
      default: begin
        last_step = CSRW_LAST;
        capture   = (step_q == CSRW_CAP);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          state_d = S_ISSUE;
          step_d  = 3'd0;
        end
      end
      S_ISSUE: begin
        if (inst_valid_q && bus.i_inst_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_res_valid) begin
          if (bus.i_res_exc) begin
            state_d = S_RESP;
`ifdef DBG_SCRATCH_SAVE_EN
            // Trap after a completed save still has to put the scratch register back.
            if (op_q == OP_CSR_WRITE && step_q != 3'd0 && step_q < CSRW_RESTORE) begin
              state_d = S_ISSUE;
              step_d  = CSRW_RESTORE;
            end
`endif
          end else if (step_q == last_step) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
            step_d  = step_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  // The first instruction is encoded straight from the command inputs in the accept cycle.
  assign e_op   = accept ? bus.i_cmd_op   : op_q;
  assign e_addr = accept ? bus.i_cmd_addr : addr_q;
  assign e_data = accept ? bus.i_cmd_data : data_q;
  assign e_step = accept ? 3'd0           : step_q;
  assign e_hi   = hi_part(e_data[31:11]);

  always_comb begin
    e_inst = 32'd0;
    case (e_op)
      OP_REG_READ:  e_inst = enc_addi(12'd0, e_addr[4:0], 5'd0);
      OP_REG_WRITE: e_inst = (e_step == 3'd0) ? enc_lui(e_hi, e_addr[4:0])
                                              : enc_addi(e_data[11:0], e_addr[4:0], e_addr[4:0]);
      OP_CSR_READ:  e_inst = {e_addr, 5'd0, 3'b010, 5'd0, 7'b1110011};
      default: begin
`ifdef DBG_SCRATCH_SAVE_EN
        case (e_step)
          3'd0:    e_inst = enc_addi(12'd0, SCRATCH_REG, 5'd0);
          3'd1:    e_inst = enc_lui(e_hi, SCRATCH_REG);
          3'd2:    e_inst = enc_addi(e_data[11:0], SCRATCH_REG, SCRATCH_REG);
          3'd3:    e_inst = {e_addr, SCRATCH_REG, 3'b001, 5'd0, 7'b1110011};
          3'd4:    e_inst = enc_lui(hi_part(save_q[31:11]), SCRATCH_REG);
          default: e_inst = enc_addi(save_q[11:0], SCRATCH_REG, SCRATCH_REG);
        endcase
`else
        case (e_step)
          3'd0:    e_inst = enc_lui(e_hi, SCRATCH_REG);
          3'd1:    e_inst = enc_addi(e_data[11:0], SCRATCH_REG, SCRATCH_REG);
          default: e_inst = {e_addr, SCRATCH_REG, 3'b001, 5'd0, 7'b1110011};
        endcase
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q         <= 2'd0;
      addr_q       <= 12'd0;
      data_q       <= 32'd0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
    end else begin
      if (accept) begin
        op_q       <= bus.i_cmd_op;
        addr_q     <= bus.i_cmd_addr;
        data_q     <= bus.i_cmd_data;
        rsp_data_q <= 32'd0;
        rsp_err_q  <= 1'b0;
      end
      if (load_inst) begin
        inst_q       <= e_inst;
        inst_valid_q <= 1'b1;
      end else if (state_q == S_ISSUE && bus.i_inst_ready) begin
        inst_valid_q <= 1'b0;
      end
      if (res_ok) begin
        if (capture) rsp_data_q <= bus.i_res_data;
        if (bus.i_res_exc) rsp_err_q <= 1'b1;
      end
    end
  end

`ifdef DBG_SCRATCH_SAVE_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      save_q <= 32'd0;
    end else if (res_ok && !bus.i_res_exc && op_q == OP_CSR_WRITE && step_q == 3'd0) begin
      save_q <= bus.i_res_data;
    end
  end
`endif

  assign bus.o_cmd_ready  = (state_q == S_IDLE);
  assign bus.o_inst_valid = inst_valid_q;
  assign bus.o_inst       = inst_q;
  assign bus.o_rsp_valid  = (state_q == S_RESP);
  assign bus.o_rsp_data   = rsp_data_q;
  assign bus.o_rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_dbg_inst_seq.sv
// tb/tb_dbg_inst_seq.sv - scoreboard bench for dbg_inst_seq with a simple core model
`timescale 1ns/1ps
module tb_dbg_inst_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dbg_inst_seq_if bus();

  dbg_inst_seq #(.SCRATCH_REG(5'd31)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          lat;
    int          acc_cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] data;
    logic        exc;
  } res_t;

  rsp_t        exp_rsp[$];
  res_t        res_q[$];
  logic [31:0] exp_inst[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_skip = 0;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_inst(input logic [31:0] w);
    exp_inst.push_back(w);
  endtask

  task automatic push_res(input logic [31:0] d, input logic exc);
    res_t r;
    r.data = d;
    r.exc  = exc;
    res_q.push_back(r);
  endtask

  // Core model: accepts each instruction one cycle after it appears, result on the next cycle.
  initial begin : core
    logic pend;
    res_t r;
    pend = 1'b0;
    bus.i_inst_ready = 1'b0;
    bus.i_res_valid  = 1'b0;
    bus.i_res_data   = 32'd0;
    bus.i_res_exc    = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_inst_ready = 1'b0;
      bus.i_res_valid  = 1'b0;
      bus.i_res_exc    = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (res_q.size() > 0) r = res_q.pop_front();
        else begin
          r.data = 32'd0;
          r.exc  = 1'b0;
        end
        bus.i_res_valid = 1'b1;
        bus.i_res_data  = r.data;
        bus.i_res_exc   = r.exc;
        pend = 1'b0;
      end else if (bus.o_inst_valid) begin
        if (exp_inst.size() == 0) begin
          chk("inst_unexpected", bus.o_inst, 32'hxxxx_xxxx ^ 32'hxxxx_xxxx);
          bus.i_inst_ready = 1'b1;
          pend = 1'b1;
        end else if (stall_skip == 0 && stall_left > 0) begin
          chk("inst_stable_stalled", bus.o_inst, exp_inst[0]);
          stall_left--;
        end else begin
          chk("inst_word", bus.o_inst, exp_inst.pop_front());
          bus.i_inst_ready = 1'b1;
          pend = 1'b1;
          if (stall_skip > 0) stall_skip--;
        end
      end
    end
  end

  initial begin : mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {31'd0, bus.o_rsp_valid}, 32'd0);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_err", {31'd0, bus.o_rsp_err}, {31'd0, e.err});
          if (e.chk_data) chk("rsp_data", bus.o_rsp_data, e.data);
          chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          chk("cmd_ready_in_resp", {31'd0, bus.o_cmd_ready}, 32'd0);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_data, input logic exp_err, input logic chk_data,
                      input int lat);
    rsp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", {31'd0, bus.o_cmd_ready}, 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = data;
    e.data     = exp_data;
    e.err      = exp_err;
    e.chk_data = chk_data;
    e.lat      = lat;
    e.acc_cyc  = cyc;
    exp_rsp.push_back(e);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", {31'd0, bus.o_cmd_ready}, 32'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_rsp_pending"}, 32'(exp_rsp.size()), 32'd0);
    @(negedge clk);
    chk({name, "_inst_left"}, 32'(exp_inst.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_cmd_ready"},  {31'd0, bus.o_cmd_ready},  32'd1);
    chk({name, "_inst_valid"}, {31'd0, bus.o_inst_valid}, 32'd0);
    chk({name, "_inst"},       bus.o_inst,                32'd0);
    chk({name, "_rsp_valid"},  {31'd0, bus.o_rsp_valid},  32'd0);
    chk({name, "_rsp_data"},   bus.o_rsp_data,            32'd0);
    chk({name, "_rsp_err"},    {31'd0, bus.o_rsp_err},    32'd0);
  endtask

  initial begin : stim
    int n;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 2'd0;
    bus.i_cmd_addr  = 12'd0;
    bus.i_cmd_data  = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    push_inst(32'h0003_8013); push_res(32'h1234_5678, 1'b0);
    send(2'd0, 12'd7, 32'd0, 32'h1234_5678, 1'b0, 1'b1, 3);
    wait_done("reg_read_x7");

    push_inst(32'h0000_1537); push_res(32'h0000_1000, 1'b0);
    push_inst(32'hFFF5_0513); push_res(32'h0000_0FFF, 1'b0);
    send(2'd1, 12'd10, 32'h0000_0FFF, 32'd0, 1'b0, 1'b1, 6);
    wait_done("reg_write_x10");

    push_inst(32'h0000_02B7); push_res(32'h0000_0000, 1'b0);
    push_inst(32'h8002_8293); push_res(32'hFFFF_F800, 1'b0);
    send(2'd1, 12'd5, 32'hFFFF_F800, 32'd0, 1'b0, 1'b1, 6);
    wait_done("reg_write_hi_wrap");

    push_inst(32'h3000_2073); push_res(32'h0000_1800, 1'b0);
    send(2'd2, 12'h300, 32'd0, 32'h0000_1800, 1'b0, 1'b1, 3);
    wait_done("csr_read_mstatus");

`ifdef DBG_SCRATCH_SAVE_EN
    push_inst(32'h000F_8013); push_res(32'hDEAD_BEEF, 1'b0);
    push_inst(32'h8000_0FB7); push_res(32'h8000_0000, 1'b0);
    push_inst(32'h000F_8F93); push_res(32'h8000_0000, 1'b0);
    push_inst(32'h341F_9073); push_res(32'h0000_1234, 1'b0);
    push_inst(32'hDEAD_CFB7); push_res(32'hDEAD_C000, 1'b0);
    push_inst(32'hEEFF_8F93); push_res(32'hDEAD_BEEF, 1'b0);
    send(2'd3, 12'h341, 32'h8000_0000, 32'h0000_1234, 1'b0, 1'b1, 18);
`else
    push_inst(32'h8000_0FB7); push_res(32'h8000_0000, 1'b0);
    push_inst(32'h000F_8F93); push_res(32'h8000_0000, 1'b0);
    push_inst(32'h341F_9073); push_res(32'h0000_1234, 1'b0);
    send(2'd3, 12'h341, 32'h8000_0000, 32'h0000_1234, 1'b0, 1'b1, 9);
`endif
    wait_done("csr_write_mepc");

    push_inst(32'hFFF0_2073); push_res(32'h0000_0000, 1'b1);
    send(2'd2, 12'hFFF, 32'd0, 32'd0, 1'b1, 1'b0, 3);
    wait_done("csr_read_trap");

    push_inst(32'h0003_8013); push_res(32'hA5A5_0001, 1'b0);
    send(2'd0, 12'd7, 32'd0, 32'hA5A5_0001, 1'b0, 1'b1, 3);
    wait_done("err_cleared");

    // Trap on the CSRRW itself; any restore steps must still run.
`ifdef DBG_SCRATCH_SAVE_EN
    push_inst(32'h000F_8013); push_res(32'h0000_0000, 1'b0);
    push_inst(32'h0000_1FB7); push_res(32'h0000_1000, 1'b0);
    push_inst(32'h800F_8F93); push_res(32'h0000_0800, 1'b0);
    push_inst(32'hC00F_9073); push_res(32'h0000_0000, 1'b1);
    push_inst(32'h0000_0FB7); push_res(32'h0000_0000, 1'b0);
    push_inst(32'h000F_8F93); push_res(32'h0000_0000, 1'b0);
    send(2'd3, 12'hC00, 32'h0000_0800, 32'd0, 1'b1, 1'b0, 18);
`else
    push_inst(32'h0000_1FB7); push_res(32'h0000_1000, 1'b0);
    push_inst(32'h800F_8F93); push_res(32'h0000_0800, 1'b0);
    push_inst(32'hC00F_9073); push_res(32'h0000_0000, 1'b1);
    send(2'd3, 12'hC00, 32'h0000_0800, 32'd0, 1'b1, 1'b0, 9);
`endif
    wait_done("csr_write_trap");

    push_inst(32'h0000_1537); push_res(32'h0000_1000, 1'b0);
    push_inst(32'hFFF5_0513); push_res(32'h0000_0FFF, 1'b0);
    stall_skip = 1;
    stall_left = 5;
    send(2'd1, 12'd10, 32'h0000_0FFF, 32'd0, 1'b0, 1'b1, 6);
    n = 0;
    while (stall_left > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_cycles_done", 32'(stall_left), 32'd0);
    #2 rst_n = 1'b0;
    exp_inst.delete();
    res_q.delete();
    exp_rsp.delete();
    stall_left = 0;
    stall_skip = 0;
    @(negedge clk);
    chk_reset_outputs("mid_cmd_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    chk("post_reset_inst_valid", {31'd0, bus.o_inst_valid}, 32'd0);

    push_inst(32'h0000_0013); push_res(32'h0000_0000, 1'b0);
    send(2'd0, 12'd0, 32'd0, 32'd0, 1'b0, 1'b1, 3);
    wait_done("reg_read_x0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
